// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch stage feeding the dual-issue decode/hazard stage.
// Holds the byte PC, issues one 64-bit doubleword read per cycle to the
// instruction local store (1-cycle synchronous read), freezes on stall with a
// 1-entry skid buffer, and redirects on branch_taken.
// Optional: define FETCH_PERF_CNT_EN to add saturating performance counters.
module instr_fetch_unit #(
    parameter int          LS_ADDR_W = 15,
    parameter logic [0:31] RESET_PC  = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [0:31]          branch_target,
    output logic                 imem_rd_en,
    output logic [0:LS_ADDR_W-1] imem_addr,
    input  logic [0:63]          imem_rdata,
    output logic [0:31]          instruction_in1,
    output logic [0:31]          instruction_in2,
    output logic [0:31]          pc_out,
    output logic                 fetch_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [0:31]          perf_fetch_cnt,
    output logic [0:31]          perf_stall_cnt,
    output logic [0:15]          perf_redirect_cnt
`endif
);

    typedef enum logic [1:0] {ST_RUN, ST_HOLD, ST_REDIR} state_t;

    localparam logic [0:31] NOP_EVEN = 32'h4020_0000;
    localparam logic [0:31] NOP_ODD  = 32'h0020_0000;

    state_t      r_state;
    logic [0:31] r_pc;
    logic [0:31] r_rd_pc;        // byte PC of the read in flight
    logic        r_rd_pending;   // a read was issued last cycle
    logic        r_rd_odd;       // in-flight read is the odd-word redirect target
    logic        r_odd_first;    // next issued read starts at the odd word
    logic        r_kill;         // discard the response arriving this cycle

    logic        r_skid_valid;
    logic [0:31] r_skid_i1;
    logic [0:31] r_skid_i2;
    logic [0:31] r_skid_pc;

    logic [0:31] r_out_i1;
    logic [0:31] r_out_i2;
    logic [0:31] r_out_pc;
    logic        r_out_valid;

    logic        w_issue;
    logic        w_rx_valid;
    logic [0:31] w_rx_i1;
    logic [0:31] w_branch_pc;
    logic        w_load_valid;
    logic        w_unused_tgt;

    // A read goes out in RUN/HOLD when not stalled, and always in REDIR (the
    // target pair then lands in the skid if decode is still stalled).
    assign w_issue      = !rst && !branch_taken && (r_state == ST_REDIR || !stall);
    assign imem_rd_en   = w_issue;
    assign imem_addr    = r_pc[29-LS_ADDR_W:28];

    assign w_rx_valid   = r_rd_pending && !r_kill;
    assign w_rx_i1      = r_rd_odd ? NOP_EVEN : imem_rdata[0:31];
    assign w_branch_pc  = {branch_target[0:28], 3'b000};
    assign w_load_valid = !branch_taken && !stall && (r_skid_valid || w_rx_valid);
    assign w_unused_tgt = ^branch_target[30:31];

    // PC, outstanding-read tracking and redirect bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every clocked register is written with <= so all of them
        // update from the same pre-edge values regardless of statement order.
        if (rst) begin
            r_pc         <= RESET_PC;
            r_rd_pc      <= '0;
            r_rd_pending <= 1'b0;
            r_rd_odd     <= 1'b0;
            r_odd_first  <= 1'b0;
            r_kill       <= 1'b0;
        end else begin
            r_rd_pending <= w_issue;
            r_kill       <= branch_taken;
            if (branch_taken) begin
                r_pc        <= w_branch_pc;
                r_odd_first <= branch_target[29];
            end else if (w_issue) begin
                r_pc        <= r_pc + 32'd8;
                r_rd_pc     <= r_pc;
                r_rd_odd    <= r_odd_first;
                r_odd_first <= 1'b0;
            end
        end
    end

    // Control FSM with registered output pair and skid buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_out_i1     <= NOP_EVEN;
            r_out_i2     <= NOP_ODD;
            r_out_pc     <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            // NOTE: the skid payload is qualified by r_skid_valid; it is reset
            // anyway so nothing stale is ever observable on a debug probe.
            r_skid_i1    <= NOP_EVEN;
            r_skid_i2    <= NOP_ODD;
            r_skid_pc    <= '0;
        end else if (branch_taken) begin
            r_state      <= ST_REDIR;
            r_out_i1     <= NOP_EVEN;
            r_out_i2     <= NOP_ODD;
            r_out_pc     <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (stall) begin
            // Outputs frozen; catch the pair that was already in flight.
            r_state <= ST_HOLD;
            if (w_rx_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_i1    <= w_rx_i1;
                r_skid_i2    <= imem_rdata[32:63];
                r_skid_pc    <= r_rd_pc;
            end
        end else begin
            // Skid drains first; otherwise take the returning data or a bubble.
            r_state      <= ST_RUN;
            r_skid_valid <= 1'b0;
            r_out_valid  <= w_load_valid;
            if (r_skid_valid) begin
                r_out_i1 <= r_skid_i1;
                r_out_i2 <= r_skid_i2;
                r_out_pc <= r_skid_pc;
            end else if (w_rx_valid) begin
                r_out_i1 <= w_rx_i1;
                r_out_i2 <= imem_rdata[32:63];
                r_out_pc <= r_rd_pc;
            end else begin
                r_out_i1 <= NOP_EVEN;
                r_out_i2 <= NOP_ODD;
                r_out_pc <= '0;
            end
        end
    end

    assign instruction_in1 = r_out_i1;
    assign instruction_in2 = r_out_i2;
    assign pc_out          = r_out_pc;
    assign fetch_valid     = r_out_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [0:31] r_perf_fetch;
    logic [0:31] r_perf_stall;
    logic [0:15] r_perf_redir;

    // Saturating event counters: delivered pairs, stall cycles, redirects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
            r_perf_redir <= '0;
        end else begin
            if (w_load_valid && !(&r_perf_fetch))
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if (stall && !(&r_perf_stall))
                r_perf_stall <= r_perf_stall + 32'd1;
            if (branch_taken && !(&r_perf_redir))
                r_perf_redir <= r_perf_redir + 16'd1;
        end
    end

    assign perf_fetch_cnt    = r_perf_fetch;
    assign perf_stall_cnt    = r_perf_stall;
    assign perf_redirect_cnt = r_perf_redir;
`endif

endmodule
